pixel_clock_tx: RTL

//  Transmit end of the pixel-clock path. Runs on the x6 system clock and

---
 rtl/pixel_clock_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pixel_clock_tx.sv
// Regenerates a 50% duty pixel clock and its data bus from the x6 system clock,
// phase-locked to the x1 reference pulse, with flywheel and lock detection.
module pixel_clock_tx #(
   parameter int DIV          = 6,
   parameter int DATA_WIDTH   = 12,
   parameter int RISE_PHASE   = 0,
   parameter int LOCK_COUNT   = 16,
   parameter int UNLOCK_COUNT = 4
) (
   input  logic                  pixelClockX6_in,
   input  logic                  reset_in,
   input  logic                  pixelClockX1_en,
   input  logic [DATA_WIDTH-1:0] pixelData_in,
   output logic                  pixelClock_out,
   output logic [DATA_WIDTH-1:0] pixelData_out,
   output logic                  locked_out
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] LAST_PH     = PW'(DIV - 1);
   localparam logic [PW-1:0] FALL_PH     = PW'((RISE_PHASE + DIV / 2) % DIV);
   localparam logic [PW:0]   REL_OFS     = (PW+1)'((DIV - RISE_PHASE) % DIV);
   localparam logic [PW:0]   DIV_W       = (PW+1)'(DIV);
   localparam logic [PW:0]   HALF_W      = (PW+1)'(DIV / 2);
   localparam logic [7:0]    LOCK_LAST   = 8'(LOCK_COUNT - 1);
   localparam logic [7:0]    UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         phase_q, phase_d;
   logic [7:0]            good_cnt_q, good_cnt_d;
   logic [7:0]            bad_cnt_q, bad_cnt_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  clk_q, clk_d;
   logic                  locked_q, locked_d;

   logic          phase_at0, good_pulse, bad_event, realign;
   logic [PW-1:0] eff_phase;
   logic [PW:0]   rel_phase;

   always_comb begin
      phase_at0  = (phase_q == '0);
      good_pulse = pixelClockX1_en && phase_at0;
      // misplaced pulse or missing phase-0 pulse; never both on one cycle
      bad_event  = pixelClockX1_en ^ phase_at0;
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      realign    = 1'b0;

      case (state_q)
         SEARCH: begin
            if (pixelClockX1_en) begin
               realign    = 1'b1;
               good_cnt_d = '0;
               state_d    = TRACK;
            end
         end
         TRACK: begin
            if (good_pulse) begin
               if (good_cnt_q == LOCK_LAST) begin
                  state_d    = LOCKED;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
               end else begin
                  good_cnt_d = good_cnt_q + 8'd1;
               end
            end else if (pixelClockX1_en) begin
               realign    = 1'b1;
               good_cnt_d = '0;
            end else if (phase_at0) begin
               good_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (good_pulse) begin
               bad_cnt_d = '0;
            end else if (bad_event) begin
               if (bad_cnt_q == UNLOCK_LAST) begin
                  state_d    = SEARCH;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
               end else begin
                  bad_cnt_d = bad_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase

      // A realigning pulse cycle is treated as phase 0 for everything downstream.
      eff_phase = realign ? '0 : phase_q;
      phase_d   = realign ? PW'(1) : ((phase_q == LAST_PH) ? '0 : phase_q + 1'b1);

      rel_phase = {1'b0, eff_phase} + REL_OFS;
      if (rel_phase >= DIV_W) rel_phase = rel_phase - DIV_W;

      // Gating on the next state kills the clock on the same edge as lock loss.
      clk_d  = (state_d != SEARCH) && (rel_phase < HALF_W);
      hold_d = hold_q;
      data_d = data_q;
      if (state_d == SEARCH) begin
         hold_d = '0;
         data_d = '0;
      end else begin
         if (eff_phase == '0)     hold_d = pixelData_in;
         if (eff_phase == FALL_PH) data_d = hold_q;
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge pixelClockX6_in or posedge reset_in) begin
      if (reset_in) begin
         state_q    <= SEARCH;
         phase_q    <= '0;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         hold_q     <= '0;
         data_q     <= '0;
         clk_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         hold_q     <= hold_d;
         data_q     <= data_d;
         clk_q      <= clk_d;
         locked_q   <= locked_d;
      end
   end

   assign pixelClock_out = clk_q;
   assign pixelData_out  = data_q;
   assign locked_out     = locked_q;

endmodule
